feature_flag_reporter: RTL and testbench
========================================

Name: feature_flag_reporter

Overview:
Run-time readout of build-time feature configuration. The block holds NUM_FLAGS configured feature flags, each with an optional parent flag, which models nested conditional compilation. A flag is effective only if it and every ancestor are set. After reset it resolves the effective flags sequentially. On request it streams a framed byte report over a valid/ready interface to the debug/status path.

Parameters:
NUM_FLAGS, 8, number of flags; legal range 1..64.
FLAG_VALUE, 64'h0, raw flag settings; bit i is flag i; bits >= NUM_FLAGS are ignored.
PARENT_MAP, {64{8'hFF}}, packed 8-bit parent index per flag; byte i is the parent of flag i; 8'hFF means root (no parent).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req  in  1  request one report frame; single-cycle pulse
out_data  out  8  frame byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts byte
busy  out  1  resolve or frame in progress
resolved  out  1  effective flags valid
eff_flags  out  64  effective flags; bits >= NUM_FLAGS are 0
err_cfg  out  1  sticky; illegal parent seen

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: out_data=0, out_valid=0, busy=1, resolved=0, eff_flags=0, err_cfg=0, FSM=RESOLVE, idx=0.
- RESOLVE state:
  - Processes one flag per cycle, idx = 0..NUM_FLAGS-1.
  - Root flag: eff[i] = raw[i].
  - Legal parent p (p < i): eff[i] = raw[i] & eff[p].
  - Illegal parent (p >= i and p != 8'hFF): eff[i] = 0 and err_cfg is set.
  - After the last index: resolved=1 and busy=0 are registered, and the FSM goes to IDLE.
  - Total latency: resolved rises NUM_FLAGS+1 cycles after the cycle in which rst is sampled low.
- req is ignored while in RESOLVE or during a frame. It is not queued.
- IDLE: on req=1, go to HDR, set busy=1, load the checksum accumulator with 0.
- Frame byte order:
  - HDR: 8'hA5.
  - CNT: NUM_FLAGS.
  - DATA: ceil(NUM_FLAGS/8) bytes of eff_flags, least-significant byte first; unused bits are 0.
  - CSUM: XOR of all preceding frame bytes.
- Handshake:
  - out_valid stays high from the first byte of a frame until the last byte is accepted.
  - A byte advances only on out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - There are no gaps between bytes when out_ready stays high: 1 byte/cycle.
- After the final accepted byte: out_valid=0 and busy=0 on the next cycle, and the FSM returns to IDLE. req in that same cycle is ignored.
- The data-byte counter is sized for up to 8 bytes and wraps only at frame end.
- Reset mid-frame or mid-resolve:
  - out_valid drops on the next edge.
  - Any partial frame is abandoned, with no completion.
  - Resolve restarts from idx=0, and err_cfg clears.
- eff_flags and err_cfg hold between frames. They change only in RESOLVE.

Optional Feature:
FLAG_REPORT_CSUM_EN.
- Defined: the CSUM byte is appended. Frame length = 3 + ceil(NUM_FLAGS/8) bytes.
- Undefined: there is no CSUM state and no accumulator. The frame ends after the last DATA byte. Frame length = 2 + ceil(NUM_FLAGS/8) bytes.
- All other behaviour is identical.

Test Plan:
1. Resolve with NUM_FLAGS=4, FLAG_VALUE=4'b1011, parents {0:FF, 1:0, 2:1, 3:2}. Release rst, out_ready=1. Required: resolved rises 5 cycles after reset release; eff_flags=64'h3; err_cfg=0.
2. Same config, one req. Required: bytes A5, 04, 03, A2 on 4 consecutive cycles; busy falls the cycle after A2. Without FLAG_REPORT_CSUM_EN: A5, 04, 03 only.
3. Backpressure. Hold out_ready=0 for 3 cycles at the CNT byte. Required: out_data holds 04 with out_valid=1; the frame completes normally after out_ready=1.
4. Request rejection. Pulse req during RESOLVE and again mid-frame. Required: no extra frame afterwards; exactly one frame is observed.
5. Illegal parent. Set NUM_FLAGS=10, FLAG_VALUE=10'h3FF, flag 5 parent 7. Required: err_cfg=1; eff_flags=10'h3DF; the frame carries 2 data bytes, DF then 03.
6. Reset mid-frame. Assert rst during the DATA byte. Required: out_valid=0 next cycle; resolved=0 until resolve completes again; a new req yields a full correct frame.

Source files
------------

// File: rtl/feature_flag_reporter_if.sv
// Byte stream carrying feature-flag report frames to the debug/status path.
interface feature_flag_reporter_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/feature_flag_reporter.sv
// Resolves nested build-time feature flags after reset and streams them as a framed report.
// Optional trailing XOR checksum byte enabled by `define FLAG_REPORT_CSUM_EN.
module feature_flag_reporter #(
  parameter int           NUM_FLAGS  = 8,
  parameter logic [63:0]  FLAG_VALUE = 64'h0,
  parameter logic [511:0] PARENT_MAP = {64{8'hFF}}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  feature_flag_reporter_if.master        stream,
  output logic                           busy,
  output logic                           resolved,
  output logic [63:0]                    eff_flags,
  output logic                           err_cfg
);

  localparam int         NBYTES    = (NUM_FLAGS + 7) / 8;
  localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);
  localparam logic [6:0] LAST_IDX  = 7'(NUM_FLAGS);

  typedef enum logic [2:0] {
    RESOLVE,
    IDLE,
    HDR,
    CNT,
`ifdef FLAG_REPORT_CSUM_EN
    CSUM,
`endif
    DATA
  } state_t;

  state_t      state_reg, state_next;
  logic [6:0]  idx_reg, idx_next;
  logic [2:0]  byte_idx_reg, byte_idx_next;
  logic [63:0] eff_reg, eff_next;
  logic        err_reg, err_next;
  logic        busy_reg, busy_next;
  logic        resolved_reg, resolved_next;
  logic [7:0]  out_data_reg, out_data_next;
  logic        out_valid_reg, out_valid_next;
`ifdef FLAG_REPORT_CSUM_EN
  logic [7:0]  csum_reg, csum_next;
`endif

  logic [7:0]  data_bytes [8];
  logic [7:0]  parent;
  logic        accept;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bytes
      assign data_bytes[gi] = eff_reg[gi*8 +: 8];
    end
  endgenerate

  assign parent = PARENT_MAP[{idx_reg[5:0], 3'b000} +: 8];
  assign accept = out_valid_reg & stream.out_ready;

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    byte_idx_next  = byte_idx_reg;
    eff_next       = eff_reg;
    err_next       = err_reg;
    busy_next      = busy_reg;
    resolved_next  = resolved_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
`ifdef FLAG_REPORT_CSUM_EN
    csum_next      = csum_reg;
`endif
    case (state_reg)
      RESOLVE: begin
        if (idx_reg == LAST_IDX) begin
          resolved_next = 1'b1;
          busy_next     = 1'b0;
          state_next    = IDLE;
        end else begin
          // Parents must precede the child so their effective value is already final.
          if (parent == 8'hFF) begin
            eff_next[idx_reg[5:0]] = FLAG_VALUE[idx_reg[5:0]];
          end else if (parent < {1'b0, idx_reg}) begin
            eff_next[idx_reg[5:0]] = FLAG_VALUE[idx_reg[5:0]] & eff_reg[parent[5:0]];
          end else begin
            eff_next[idx_reg[5:0]] = 1'b0;
            err_next               = 1'b1;
          end
          idx_next = idx_reg + 7'd1;
        end
      end
      IDLE: begin
        if (req) begin
          state_next     = HDR;
          busy_next      = 1'b1;
          out_valid_next = 1'b1;
          out_data_next  = 8'hA5;
`ifdef FLAG_REPORT_CSUM_EN
          csum_next      = 8'h00;
`endif
        end
      end
      HDR: begin
        if (accept) begin
          state_next    = CNT;
          out_data_next = 8'(NUM_FLAGS);
`ifdef FLAG_REPORT_CSUM_EN
          csum_next     = csum_reg ^ out_data_reg;
`endif
        end
      end
      CNT: begin
        if (accept) begin
          state_next    = DATA;
          byte_idx_next = 3'd0;
          out_data_next = data_bytes[0];
`ifdef FLAG_REPORT_CSUM_EN
          csum_next     = csum_reg ^ out_data_reg;
`endif
        end
      end
      DATA: begin
        if (accept) begin
`ifdef FLAG_REPORT_CSUM_EN
          csum_next = csum_reg ^ out_data_reg;
`endif
          if (byte_idx_reg == LAST_BYTE) begin
            byte_idx_next  = 3'd0;
`ifdef FLAG_REPORT_CSUM_EN
            state_next     = CSUM;
            out_data_next  = csum_reg ^ out_data_reg;
`else
            state_next     = IDLE;
            out_valid_next = 1'b0;
            busy_next      = 1'b0;
            out_data_next  = 8'h00;
`endif
          end else begin
            byte_idx_next = byte_idx_reg + 3'd1;
            out_data_next = data_bytes[byte_idx_reg + 3'd1];
          end
        end
      end
`ifdef FLAG_REPORT_CSUM_EN
      CSUM: begin
        if (accept) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
          busy_next      = 1'b0;
          out_data_next  = 8'h00;
        end
      end
`endif
      default: state_next = RESOLVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RESOLVE;
      idx_reg       <= 7'd0;
      byte_idx_reg  <= 3'd0;
      eff_reg       <= 64'h0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b1;
      resolved_reg  <= 1'b0;
      out_data_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
`ifdef FLAG_REPORT_CSUM_EN
      csum_reg      <= 8'h00;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      byte_idx_reg  <= byte_idx_next;
      eff_reg       <= eff_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      resolved_reg  <= resolved_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
`ifdef FLAG_REPORT_CSUM_EN
      csum_reg      <= csum_next;
`endif
    end
  end

  assign stream.out_data  = out_data_reg;
  assign stream.out_valid = out_valid_reg;
  assign busy             = busy_reg;
  assign resolved         = resolved_reg;
  assign eff_flags        = eff_reg;
  assign err_cfg          = err_reg;

endmodule

// File: tb/tb_feature_flag_reporter.sv
// Directed scoreboard bench for feature_flag_reporter using two configurations.
module tb_feature_flag_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, req_a, req_b;
  logic busy_a, busy_b, res_a, res_b, err_a, err_b;
  logic [63:0] eff_a, eff_b;

  feature_flag_reporter_if if_a ();
  feature_flag_reporter_if if_b ();

  feature_flag_reporter #(
    .NUM_FLAGS (4),
    .FLAG_VALUE(64'hB),
    .PARENT_MAP({{60{8'hFF}}, 8'h02, 8'h01, 8'h00, 8'hFF})
  ) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .stream(if_a),
    .busy(busy_a), .resolved(res_a), .eff_flags(eff_a), .err_cfg(err_a)
  );

  feature_flag_reporter #(
    .NUM_FLAGS (10),
    .FLAG_VALUE(64'h3FF),
    .PARENT_MAP({{58{8'hFF}}, 8'h07, {5{8'hFF}}})
  ) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .stream(if_b),
    .busy(busy_b), .resolved(res_b), .eff_flags(eff_b), .err_cfg(err_b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input bit sel);
    return sel ? if_b.out_valid : if_a.out_valid;
  endfunction
  function automatic logic [7:0] dat(input bit sel);
    return sel ? if_b.out_data : if_a.out_data;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic rsv(input bit sel);
    return sel ? res_b : res_a;
  endfunction

  task automatic set_req(input bit sel, input logic v);
    if (sel) req_b = v; else req_a = v;
  endtask
  task automatic set_ready(input bit sel, input logic v);
    if (sel) if_b.out_ready = v; else if_a.out_ready = v;
  endtask

  // Expected frame built from the bench's own view of the effective flags.
  task automatic push_frame(input int n, input logic [63:0] eff);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'hA5 ^ 8'(n);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n));
    for (int k = 0; k < (n + 7) / 8; k++) begin
      b = eff[k*8 +: 8];
      cs = cs ^ b;
      exp_q.push_back(b);
    end
`ifdef FLAG_REPORT_CSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic send_req(input bit sel);
    set_req(sel, 1'b1);
    tick();
    set_req(sel, 1'b0);
  endtask

  // Release reset and count cycles until resolved rises.
  task automatic measure_resolve(input bit sel, input int exp_lat, input bit pulse_req);
    int cnt = 0;
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    while (cnt < 200) begin
      if (pulse_req && cnt == 1) set_req(sel, 1'b1);
      tick();
      set_req(sel, 1'b0);
      cnt++;
      if (rsv(sel)) break;
    end
    check("resolve_latency", 64'(cnt), 64'(exp_lat));
    check("busy_after_resolve", 64'(bsy(sel)), 64'd0);
  endtask

  task automatic collect(input bit sel, input int nbytes, input bit full,
                         input int stall_at, input int stall_len, input bit req_mid);
    int w = 0;
    logic [7:0] e;
    while (!vld(sel) && w < 50) begin
      tick();
      w++;
    end
    check("frame_start_valid", 64'(vld(sel)), 64'd1);
    for (int k = 0; k < nbytes; k++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
        break;
      end
      e = exp_q.pop_front();
      check($sformatf("byte%0d_valid", k), 64'(vld(sel)), 64'd1);
      check($sformatf("byte%0d_data", k), 64'(dat(sel)), 64'(e));
      if (k == stall_at) begin
        set_ready(sel, 1'b0);
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_valid", 64'(vld(sel)), 64'd1);
          check("stall_data", 64'(dat(sel)), 64'(e));
        end
        set_ready(sel, 1'b1);
      end
      if (req_mid && k == 1) set_req(sel, 1'b1);
      tick();
      set_req(sel, 1'b0);
    end
    if (full) begin
      check("frame_end_valid", 64'(vld(sel)), 64'd0);
      check("frame_end_busy", 64'(bsy(sel)), 64'd0);
    end
  endtask

  task automatic watch_idle(input bit sel, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      check("no_extra_frame", 64'(vld(sel)), 64'd0);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    tick(); tick();

    check("rst_valid", 64'(if_a.out_valid), 64'd0);
    check("rst_data", 64'(if_a.out_data), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd1);
    check("rst_resolved", 64'(res_a), 64'd0);
    check("rst_eff", eff_a, 64'd0);
    check("rst_err", 64'(err_a), 64'd0);

    // Resolve with a req pulse that must be ignored.
    measure_resolve(1'b0, 5, 1'b1);
    check("a_eff", eff_a, 64'h3);
    check("a_err", 64'(err_a), 64'd0);
    watch_idle(1'b0, 3);

    // One frame, with a req pulse mid-frame that must not start another.
    push_frame(4, 64'h3);
    send_req(1'b0);
    collect(1'b0, exp_q.size(), 1'b1, -1, 0, 1'b1);
    watch_idle(1'b0, 10);
    check("a_queue_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure on the CNT byte.
    push_frame(4, 64'h3);
    send_req(1'b0);
    collect(1'b0, exp_q.size(), 1'b1, 1, 3, 1'b0);
    check("a_eff_hold", eff_a, 64'h3);

    // Reset while the first DATA byte is presented.
    push_frame(4, 64'h3);
    send_req(1'b0);
    collect(1'b0, 2, 1'b0, -1, 0, 1'b0);
    exp_q.delete();
    rst_a = 1'b1;
    tick();
    check("midrst_valid", 64'(if_a.out_valid), 64'd0);
    check("midrst_resolved", 64'(res_a), 64'd0);
    check("midrst_busy", 64'(busy_a), 64'd1);
    measure_resolve(1'b0, 5, 1'b0);
    check("a_eff_again", eff_a, 64'h3);
    push_frame(4, 64'h3);
    send_req(1'b0);
    collect(1'b0, exp_q.size(), 1'b1, -1, 0, 1'b0);

    // Illegal parent configuration, two data bytes.
    measure_resolve(1'b1, 11, 1'b0);
    check("b_err", 64'(err_b), 64'd1);
    check("b_eff", eff_b, 64'h3DF);
    push_frame(10, 64'h3DF);
    send_req(1'b1);
    collect(1'b1, exp_q.size(), 1'b1, 3, 2, 1'b0);
    check("b_err_hold", 64'(err_b), 64'd1);
    watch_idle(1'b1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
